// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port memory between instruction fetch and
//                the load/store stage. One transaction is outstanding at a
//                time. The MEM stage has priority, and IF wins after
//                STARVE_MAX consecutive MEM grants. A flush drops the
//                response of an in-flight fetch.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  // fetch port
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic            if_rvalid_o,
  output logic [DW-1:0]   if_rdata_o,
  // load/store port
  input  logic            dm_req_i,
  input  logic            dm_we_i,
  input  logic [AW-1:0]   dm_addr_i,
  input  logic [DW-1:0]   dm_wdata_i,
  input  logic [DW/8-1:0] dm_wstrb_i,
  output logic            dm_rvalid_o,
  output logic [DW-1:0]   dm_rdata_o,
  // memory port
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_wstrb_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [DW-1:0]   mem_rdata_i
);

  localparam int            SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            owner_if_q, owner_if_d;   // 1 = current transaction belongs to fetch
  logic            drop_q, drop_d;           // fetch response must be discarded
  logic [SW-1:0]   starve_q, starve_d;

  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW/8-1:0] mem_wstrb_q, mem_wstrb_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic            dm_rvalid_q, dm_rvalid_d;
  logic [DW-1:0]   dm_rdata_q, dm_rdata_d;

  // A fetch request presented together with a flush is stale and never competes.
  logic fetch_req;
  assign fetch_req = if_req_i & ~flush_i;

  // Next-state, arbitration and registered-output logic.
  always_comb begin
    state_d     = state_q;
    owner_if_d  = owner_if_q;
    drop_d      = drop_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rvalid_d = 1'b0;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (dm_req_i || fetch_req) begin
          if (fetch_req && (!dm_req_i || starve_q == STARVE_LIM)) begin
            owner_if_d  = 1'b1;
            starve_d    = '0;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
          end else begin
            owner_if_d  = 1'b0;
            // Count only MEM wins that actually held off a waiting fetch.
            if (fetch_req) begin
              starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);
            end else begin
              starve_d = '0;
            end
            mem_we_d    = dm_we_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
            mem_wstrb_d = dm_we_i ? dm_wstrb_i : '0;
          end
          mem_req_d = 1'b1;
          state_d   = S_ISSUE;
        end else begin
          starve_d = '0;
        end
      end

      S_ISSUE: begin
        if (owner_if_q && flush_i) begin
          drop_d = 1'b1;
        end
        // The request stays up until accepted, even across a flush.
        if (mem_gnt_i) begin
          mem_req_d   = 1'b0;
          mem_wstrb_d = '0;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (owner_if_q && flush_i) begin
          drop_d = 1'b1;
        end
        if (mem_rvalid_i) begin
          state_d = S_RESP;
          if (owner_if_q) begin
            if (!(drop_q || flush_i)) begin
              if_rvalid_d = 1'b1;
              if_rdata_d  = mem_rdata_i;
            end
          end else begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = mem_rdata_i;
          end
        end
      end

      S_RESP: begin
        drop_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_if_q  <= 1'b0;
      drop_q      <= 1'b0;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rvalid_q <= 1'b0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_if_q  <= owner_if_d;
      drop_q      <= drop_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rvalid_q <= dm_rvalid_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rvalid_o = dm_rvalid_q;
  assign dm_rdata_o  = dm_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Bench for mem_port_arbiter: directed scenarios with literal
//                expectations, then randomized traffic compared each cycle
//                against a transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_wstrb = '0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        if_rvalid, dm_rvalid, mem_req, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_wstrb_i(dm_wstrb), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_wstrb_o(mem_wstrb), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
    end
  endtask

  // ---------------- memory responder (drives at negedge) ----------------
  int          gnt_delay = 0;
  int          rsp_delay = 1;
  int          stray_pct = 0;
  bit          rand_lat  = 1'b0;
  logic [31:0] mem [0:255];
  int          ms = 0, gw = 0, rw = 0;
  logic        w_we = 1'b0;
  logic [31:0] w_addr = '0, w_wdata = '0;
  logic [3:0]  w_wstrb = '0;

  always @(negedge clk) begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (!rst_n) begin
      ms = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
      mem[4] = 32'h0050_0093;
      mem_rdata = '0;
    end else begin
      if (ms == 0) begin
        if (mem_req) begin
          gw = rand_lat ? int'($urandom_range(3)) : gnt_delay;
          ms = 1;
        end else if (int'($urandom_range(99)) < stray_pct) begin
          mem_rvalid = 1'b1;
          mem_rdata  = $urandom;
        end
      end
      if (ms == 1) begin
        if (gw == 0) begin
          mem_gnt = 1'b1;
          w_we = mem_we; w_addr = mem_addr; w_wdata = mem_wdata; w_wstrb = mem_wstrb;
          rw = rand_lat ? int'($urandom_range(4, 1)) : rsp_delay;
          ms = 2;
        end else begin
          gw--;
        end
      end else if (ms == 2) begin
        rw--;
        if (rw == 0) begin
          mem_rvalid = 1'b1;
          if (w_we) begin
            for (int b = 0; b < 4; b++)
              if (w_wstrb[b]) mem[w_addr[9:2]][8*b +: 8] = w_wdata[8*b +: 8];
            mem_rdata = $urandom;
          end else begin
            mem_rdata = mem[w_addr[9:2]];
          end
          ms = 0;
        end
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  bit          m_act, m_gnt, m_ret, m_ifown, m_drop, m_fetch;
  int          m_starve;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, e_ifd, e_dmd;
  logic [3:0]  m_wstrb;
  logic        e_ifv, e_dmv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_gnt = 0; m_ret = 0; m_ifown = 0; m_drop = 0; m_starve = 0;
      m_we = 0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
      e_ifv = 0; e_dmv = 0; e_ifd = '0; e_dmd = '0;
    end else begin
      e_ifv = 0; e_dmv = 0;
      if (!m_act) begin
        m_fetch = if_req && !flush;
        if (dm_req || m_fetch) begin
          m_ifown = m_fetch && (!dm_req || m_starve == SM);
          if (m_ifown) begin
            m_starve = 0;
            m_we = 0; m_addr = if_addr; m_wdata = '0; m_wstrb = '0;
          end else begin
            m_starve = m_fetch ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
            m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
            m_wstrb = dm_we ? dm_wstrb : 4'h0;
          end
          m_act = 1; m_gnt = 0; m_ret = 0; m_drop = 0;
        end else begin
          m_starve = 0;
        end
      end else if (!m_gnt) begin
        if (m_ifown && flush) m_drop = 1;
        if (mem_gnt) m_gnt = 1;
      end else if (!m_ret) begin
        if (m_ifown && flush) m_drop = 1;
        if (mem_rvalid) begin
          m_ret = 1;
          if (!m_ifown) begin e_dmv = 1; e_dmd = mem_rdata; end
          else if (!m_drop) begin e_ifv = 1; e_ifd = mem_rdata; end
        end
      end else begin
        m_act = 0;
      end
      #1;
      chk("mem_req",   mem_req,   m_act && !m_gnt);
      chk("mem_we",    mem_we,    m_we);
      chk("mem_addr",  mem_addr,  m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_wstrb", mem_wstrb, (m_act && !m_gnt) ? m_wstrb : 4'h0);
      chk("if_rvalid", if_rvalid, e_ifv);
      chk("dm_rvalid", dm_rvalid, e_dmv);
      chk("if_rdata",  if_rdata,  e_ifd);
      chk("dm_rdata",  dm_rdata,  e_dmd);
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_pulse(input bit want_if, input string n);
    int k = 0;
    while (k < 60 && !(want_if ? if_rvalid : dm_rvalid)) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 60) begin
      errors++;
      $display("FAIL %s: no rvalid pulse within 60 cycles (got 0 expected 1)", n);
    end
  endtask

  // Returns at the first negedge of the WAIT phase (request up, then accepted).
  task automatic wait_accepted(input string n);
    int k = 0;
    while (k < 40 && !mem_req) begin @(negedge clk); k++; end
    while (k < 40 && mem_req)  begin @(negedge clk); k++; end
    checks++;
    if (k >= 40) begin
      errors++;
      $display("FAIL %s: request not accepted within 40 cycles (got %0d expected <40)", n, k);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [4:0] pat;
  int         ng, kk;
  bit         prev, seen;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctl", {mem_req, mem_we, if_rvalid, dm_rvalid, mem_wstrb}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_addr", mem_addr, 64'h0);

    // 1: minimum-latency fetch
    @(negedge clk); if_req = 1; if_addr = 32'h10;
    @(negedge clk);
    chk("t1_memreq", mem_req, 64'h1);
    chk("t1_memwe",  mem_we,  64'h0);
    chk("t1_addr",   mem_addr, 64'h10);
    @(negedge clk);
    chk("t1_early", if_rvalid, 64'h0);
    @(negedge clk);
    chk("t1_ifv_c3", if_rvalid, 64'h1);
    chk("t1_ifdata", if_rdata, 64'h0050_0093);
    if_req = 0;
    @(negedge clk);
    chk("t1_onepulse", if_rvalid, 64'h0);

    // 2: simultaneous store and fetch, store first
    @(negedge clk);
    if_req = 1; if_addr = 32'h20;
    dm_req = 1; dm_we = 1; dm_addr = 32'h18; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'hF;
    @(negedge clk);
    chk("t2_we",    mem_we,    64'h1);
    chk("t2_addr",  mem_addr,  64'h18);
    chk("t2_wdata", mem_wdata, 64'hDEAD_BEEF);
    chk("t2_wstrb", mem_wstrb, 64'hF);
    wait_pulse(0, "t2_store");
    dm_req = 0; dm_we = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t2_fetch_req",  mem_req,  64'h1);
    chk("t2_fetch_addr", mem_addr, 64'h20);
    chk("t2_fetch_we",   mem_we,   64'h0);
    wait_pulse(1, "t2_fetch");
    chk("t2_ifdata", if_rdata, 64'h1000_0008);
    if_req = 0;
    @(negedge clk); dm_req = 1; dm_we = 0; dm_addr = 32'h18;
    wait_pulse(0, "t2_load");
    chk("t2_loaddata", dm_rdata, 64'hDEAD_BEEF);
    dm_req = 0;
    repeat (2) @(negedge clk);

    // 3: anti-starvation, expect MEM,MEM,MEM,MEM,IF
    @(negedge clk);
    dm_req = 1; dm_we = 0; dm_addr = 32'h100; if_req = 1; if_addr = 32'h200;
    pat = '0; ng = 0; prev = 0; kk = 0;
    while (ng < 5 && kk < 200) begin
      @(negedge clk); kk++;
      if (mem_req && !prev) begin
        pat = {pat[3:0], mem_addr == 32'h200};
        ng++;
        if (ng == 5) dm_req = 0;
      end
      prev = mem_req;
      if (dm_rvalid) dm_addr = dm_addr + 32'h4;
    end
    chk("t3_count",  ng,  64'd5);
    chk("t3_grants", pat, 64'b00001);
    wait_pulse(1, "t3_fetch");
    if_req = 0;
    repeat (2) @(negedge clk);

    // 4: flush while the fetch is waiting on memory
    rsp_delay = 3;
    @(negedge clk); if_req = 1; if_addr = 32'h30;
    wait_accepted("t4_accept");
    flush = 1; if_req = 0;
    @(negedge clk); flush = 0;
    seen = 0;
    repeat (10) begin @(negedge clk); if (if_rvalid) seen = 1; end
    chk("t4_suppressed", seen, 64'h0);
    chk("t4_idle", mem_req, 64'h0);
    rsp_delay = 1;
    if_req = 1; if_addr = 32'h40;
    @(negedge clk);
    chk("t4_next_addr", mem_addr, 64'h40);
    wait_pulse(1, "t4_next");
    chk("t4_next_data", if_rdata, 64'h1000_0010);
    if_req = 0;

    // 5: grant withheld three cycles, then stray responses in IDLE
    gnt_delay = 3;
    @(negedge clk);
    dm_req = 1; dm_we = 1; dm_addr = 32'h44; dm_wdata = 32'hCAFE_F00D; dm_wstrb = 4'b0101;
    repeat (3) begin
      @(negedge clk);
      chk("t5_hold_req",   mem_req,   64'h1);
      chk("t5_hold_addr",  mem_addr,  64'h44);
      chk("t5_hold_wdata", mem_wdata, 64'hCAFE_F00D);
      chk("t5_hold_strb",  mem_wstrb, 64'h5);
    end
    gnt_delay = 0;
    wait_pulse(0, "t5_store");
    dm_req = 0; dm_we = 0;
    stray_pct = 100;
    seen = 0;
    repeat (6) begin @(negedge clk); if (if_rvalid || dm_rvalid) seen = 1; end
    chk("t5_stray", seen, 64'h0);
    stray_pct = 0;

    // 6: reset asserted in the middle of a fetch
    rsp_delay = 4;
    @(negedge clk); if_req = 1; if_addr = 32'h50;
    wait_accepted("t6_accept");
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("t6_ctl",   {mem_req, mem_we, if_rvalid, dm_rvalid, mem_wstrb}, 64'h0);
    chk("t6_addr",  mem_addr,  64'h0);
    chk("t6_wdata", mem_wdata, 64'h0);
    chk("t6_rdata", {if_rdata, dm_rdata}, 64'h0);
    if_req = 0;
    rsp_delay = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    stray_pct = 100;
    seen = 0;
    repeat (8) begin @(negedge clk); if (if_rvalid || dm_rvalid) seen = 1; end
    chk("t6_after_rst", seen, 64'h0);
    stray_pct = 0;

    // randomized traffic against the reference model
    rand_lat = 1; stray_pct = 5;
    repeat (3000) begin
      @(negedge clk);
      flush = ($urandom_range(15) == 0);
      if (if_req && (if_rvalid || flush)) begin
        if_req  = $urandom_range(1);
        if_addr = 32'($urandom_range(255)) << 2;
      end else if (!if_req && $urandom_range(3) == 0) begin
        if_req  = 1;
        if_addr = 32'($urandom_range(255)) << 2;
      end
      if (dm_req && dm_rvalid) dm_req = 0;
      if (!dm_req && $urandom_range(2) == 0) begin
        dm_req   = 1;
        dm_we    = $urandom_range(1);
        dm_addr  = 32'($urandom_range(255)) << 2;
        dm_wdata = $urandom;
        dm_wstrb = 4'($urandom_range(15));
      end
    end
    flush = 0; if_req = 0; dm_req = 0; stray_pct = 0;
    repeat (20) @(negedge clk);
    rand_lat = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
